// File: rtl/fetch_ctrl_if.sv
// Memory-read and decode handshakes of the instruction-fetch controller.
// The master modport is the fetch_ctrl side. The slave modport is the memory/decode side.
interface fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues memory reads, and hands words to decode.
// Optional watchdog on stalled reads is built when FETCH_TIMEOUT_EN is defined.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] PC_STEP        = 32'd4,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   pc,
  output logic          fetch_err,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        flush_q, flush_d;
  logic        gap_q, gap_d;
  logic        req_on;
  logic        tmo;
  logic [31:0] target;

  assign req_on = (state_q == FETCH) && !gap_q;
  assign target = redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      flush_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      flush_q <= flush_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    flush_d = flush_q;
    gap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = target;
        if (en) state_d = FETCH;
      end
      FETCH: begin
        if (gap_q) begin
          if (redirect) pc_d = target;
          if (!en) state_d = IDLE;
        end else if (redirect) begin
          pc_d = target;
          if (bus.mem_ack) begin
            flush_d = 1'b0;
            gap_d   = 1'b1;
          end else begin
            // The memory still sees the original address until the stale ack returns.
            if (!flush_q) hold_d = pc_q;
            flush_d = 1'b1;
          end
        end else if (bus.mem_ack) begin
          if (flush_q) begin
            flush_d = 1'b0;
            gap_d   = 1'b1;
          end else begin
            instr_d = bus.mem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + PC_STEP;
            state_d = VALID;
          end
        end else if (tmo) begin
          flush_d = 1'b0;
          gap_d   = 1'b1;
        end
      end
      VALID: begin
        if (redirect) begin
          pc_d    = target;
          state_d = en ? FETCH : IDLE;
        end else if (bus.instr_ready) begin
          state_d = en ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Counts unanswered request cycles; the last one triggers a one-cycle drop and retry.
  assign tmo = req_on && !bus.mem_ack && !redirect &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
      if (req_on && !bus.mem_ack && !redirect && !tmo) cnt_q <= cnt_q + 1'b1;
      else cnt_q <= '0;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout;

  assign tmo            = 1'b0;
  assign fetch_err      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign bus.mem_req     = req_on;
  assign bus.mem_addr    = flush_q ? hold_q : pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = (state_q == VALID);
  assign pc              = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; memory word at address A is (A>>2)+0x100.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        fetch_err;
  int          vectors = 0;
  int          miscompares = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .fetch_err   (fetch_err),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = (bus.mem_addr >> 2) + 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    en              = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.mem_ack     = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (3) step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_ipc", bus.instr_pc, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // Sequential stream, one instruction every two cycles
    rst = 1'b1; en = 1'b1; bus.mem_ack = 1'b1; bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_req", {31'b0, bus.mem_req}, 32'd1);
      chk("seq_addr", bus.mem_addr, 32'(4 * i));
      chk("seq_valid_lo", {31'b0, bus.instr_valid}, 32'd0);
      step();
      chk("seq_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("seq_instr", bus.instr, 32'(32'h100 + i));
      chk("seq_ipc", bus.instr_pc, 32'(4 * i));
      chk("seq_req_lo", {31'b0, bus.mem_req}, 32'd0);
    end

    // Back-pressure holds the word
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("stall_instr", bus.instr, 32'h103);
      chk("stall_ipc", bus.instr_pc, 32'hC);
      chk("stall_req", {31'b0, bus.mem_req}, 32'd0);
      chk("stall_pc", pc, 32'h10);
    end

    // Redirect together with valid & ready drops the word
    bus.instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h8;
    step();
    redirect = 1'b0; bus.mem_ack = 1'b0;
    chk("rdv_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rdv_req", {31'b0, bus.mem_req}, 32'd1);
    chk("rdv_addr", bus.mem_addr, 32'h8);

    // Ack arrives on the fourth request cycle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dly_req", {31'b0, bus.mem_req}, 32'd1);
      chk("dly_addr", bus.mem_addr, 32'h8);
    end
    bus.mem_ack = 1'b1;
    step();
    chk("dly_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("dly_ipc", bus.instr_pc, 32'h8);
    chk("dly_instr", bus.instr, 32'h102);
    step();
    chk("c_addr", bus.mem_addr, 32'hC);
    step();
    chk("c_instr", bus.instr, 32'h103);
    bus.mem_ack = 1'b0;
    step();
    chk("w10_addr", bus.mem_addr, 32'h10);

    // Redirect while the read at 0x10 is outstanding
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("fl_req", {31'b0, bus.mem_req}, 32'd1);
    chk("fl_addr_held", bus.mem_addr, 32'h10);
    chk("fl_pc", pc, 32'h200);
    bus.mem_ack = 1'b1;
    step();
    chk("fl_gap", {31'b0, bus.mem_req}, 32'd0);
    chk("fl_novalid", {31'b0, bus.instr_valid}, 32'd0);
    chk("fl_instr_kept", bus.instr, 32'h103);
    chk("fl_pc2", pc, 32'h200);
    step();
    chk("fl_req2", {31'b0, bus.mem_req}, 32'd1);
    chk("fl_addr2", bus.mem_addr, 32'h200);
    step();
    chk("fl_instr", bus.instr, 32'h180);
    chk("fl_ipc", bus.instr_pc, 32'h200);

    // Wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wr_addr", bus.mem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_instr", bus.instr, 32'h4000_00FF);
    chk("wr_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wr_pc", pc, 32'h0);
    step();
    chk("wr_addr0", bus.mem_addr, 32'h0);

    // en low during a fetch: finish, wait in VALID, then go idle
    en = 1'b0;
    step();
    chk("en_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("en_instr", bus.instr, 32'h100);
    step();
    chk("en_idle_req", {31'b0, bus.mem_req}, 32'd0);
    chk("en_idle_valid", {31'b0, bus.instr_valid}, 32'd0);
    step();
    chk("en_idle_req2", {31'b0, bus.mem_req}, 32'd0);

    // Redirect coincident with the ack
    en = 1'b1;
    step();
    chk("ra_addr", bus.mem_addr, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("ra_gap", {31'b0, bus.mem_req}, 32'd0);
    chk("ra_novalid", {31'b0, bus.instr_valid}, 32'd0);
    chk("ra_pc", pc, 32'h40);
    step();
    chk("ra_addr2", bus.mem_addr, 32'h40);
    chk("ra_req2", {31'b0, bus.mem_req}, 32'd1);
    step();
    chk("ra_instr", bus.instr, 32'h110);

    // Memory never answers
    bus.mem_ack = 1'b0;
    step();
    chk("to_addr", bus.mem_addr, 32'h44);
    for (int k = 2; k <= 16; k++) begin
      step();
      chk("to_req", {31'b0, bus.mem_req}, 32'd1);
      chk("to_err_lo", {31'b0, fetch_err}, 32'd0);
    end
    step();
`ifdef FETCH_TIMEOUT_EN
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_gap", {31'b0, bus.mem_req}, 32'd0);
    step();
    chk("to_err_clr", {31'b0, fetch_err}, 32'd0);
    chk("to_retry_req", {31'b0, bus.mem_req}, 32'd1);
    chk("to_retry_addr", bus.mem_addr, 32'h44);
`else
    chk("to_err_tied", {31'b0, fetch_err}, 32'd0);
    chk("to_wait_req", {31'b0, bus.mem_req}, 32'd1);
    chk("to_wait_addr", bus.mem_addr, 32'h44);
`endif
    bus.mem_ack = 1'b1;
    step();
    chk("to_instr", bus.instr, 32'h111);
    chk("to_ipc", bus.instr_pc, 32'h44);

    // Asynchronous reset in the middle of a request
    step();
    chk("ar_req_before", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req", {31'b0, bus.mem_req}, 32'd0);
    chk("ar_pc", pc, 32'h0);
    chk("ar_instr", bus.instr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
